// File: rtl/alu_arbiter_if.sv
// Bus bundle for the two-requester ALU arbiter: requester handshakes,
// shared-ALU drive/return and the response channel.
interface alu_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [3:0]  req0_opcode;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [3:0]  req1_opcode;
  logic [31:0] req1_a, req1_b;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;
  logic        alu_z, alu_neg;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_result;
  logic        rsp_z, rsp_neg, rsp_err;

  // arbiter side
  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  alu_result, alu_z, alu_neg,
    output req0_ready, req1_ready,
    output alu_opcode, alu_a, alu_b,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_z, rsp_neg, rsp_err
  );

  // requesters + ALU side
  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output alu_result, alu_z, alu_neg,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_a, alu_b,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_z, rsp_neg, rsp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight: IDLE (grant) -> EXEC (ALU driven) -> RESP (strobe).
module alu_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        id;
  } req_t;

  state_t      state, state_nxt;
  req_t        req_q, req_in;
  logic [1:0]  vld;
  logic        gnt_id, grant, last_grant;
  logic [1:0]  z_q, neg_q;
  logic        op_supp, op_flags;
  logic [31:0] rsp_result_q;
  logic        rsp_err_q;

  assign vld = {bus.req1_valid, bus.req0_valid};

  // Pick a winner: on a tie, the requester not granted last time
  always_comb begin
    gnt_id = vld[1];
    if (vld == 2'b11) gnt_id = ~last_grant;
  end

  // Grant only from IDLE and never while reset is held
  assign grant          = (state == IDLE) && reset_n && (|vld);
  assign bus.req0_ready = grant && !gnt_id;
  assign bus.req1_ready = grant &&  gnt_id;

  // Mux the winning requester's fields for latching
  always_comb begin
    req_in.id = gnt_id;
    req_in.op = gnt_id ? bus.req1_opcode : bus.req0_opcode;
    req_in.a  = gnt_id ? bus.req1_a      : bus.req0_a;
    req_in.b  = gnt_id ? bus.req1_b      : bus.req0_b;
  end

  // Decode the latched opcode: known encodings, and those that update flags
  always_comb begin
    op_flags = req_q.op inside {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    op_supp  = op_flags || (req_q.op == 4'b1111) || (req_q.op == 4'b0000);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state: EXEC and RESP each last exactly one cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch, round-robin pointer, result capture and flag update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q        <= '0;
      last_grant   <= 1'b1;
      z_q          <= '0;
      neg_q        <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      if (grant) begin
        req_q      <= req_in;
        last_grant <= gnt_id;
      end
      if (state == EXEC) begin
        rsp_result_q <= op_supp ? bus.alu_result : 32'h0;
        rsp_err_q    <= !op_supp;
        if (op_flags) begin
          z_q[req_q.id]   <= bus.alu_z;
          neg_q[req_q.id] <= bus.alu_neg;
        end
      end
    end
  end

  // ALU is only driven during EXEC; unknown opcodes are forced to NOP
  always_comb begin
    bus.alu_opcode = 4'b0000;
    bus.alu_a      = 32'h0;
    bus.alu_b      = 32'h0;
    if (state == EXEC) begin
      bus.alu_opcode = op_supp ? req_q.op : 4'b0000;
      bus.alu_a      = req_q.a;
      bus.alu_b      = req_q.b;
    end
  end

  assign bus.rsp0_valid = (state == RESP) && !req_q.id;
  assign bus.rsp1_valid = (state == RESP) &&  req_q.id;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.rsp_z      = z_q[req_q.id];
  assign bus.rsp_neg    = neg_q[req_q.id];

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if bus ();

  alu_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  // Shared ALU; NOP returns a marker value with both flags set so that
  // wrongly captured results or flags are visible
  always_comb begin
    bus.alu_result = 32'hDEADBEEF;
    bus.alu_z      = 1'b1;
    bus.alu_neg    = 1'b1;
    case (bus.alu_opcode)
      4'b1000: bus.alu_result = bus.alu_a + bus.alu_b;
      4'b0100: bus.alu_result = bus.alu_b + 32'd1;
      4'b0010: bus.alu_result = 32'd0 - bus.alu_b;
      4'b0001: bus.alu_result = bus.alu_b - bus.alu_a;
      4'b1111: bus.alu_result = bus.alu_b;
      default: bus.alu_result = 32'hDEADBEEF;
    endcase
    if (bus.alu_opcode != 4'b0000) begin
      bus.alu_z   = (bus.alu_result == 32'h0);
      bus.alu_neg = bus.alu_result[31];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_opcode = 4'h0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_opcode = 4'h0; bus.req1_a = '0; bus.req1_b = '0;
  endtask

  // Reset values of every output (valid while reset_n is low)
  task automatic check_reset_outputs(input string tag);
    check({tag, ".rdy"},  {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check({tag, ".rspv"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    check({tag, ".res"},  bus.rsp_result, 32'h0);
    check({tag, ".fl"},   {29'd0, bus.rsp_err, bus.rsp_z, bus.rsp_neg}, 32'd0);
    check({tag, ".aop"},  {28'd0, bus.alu_opcode}, 32'd0);
    check({tag, ".aab"},  bus.alu_a | bus.alu_b, 32'h0);
  endtask

  // Called at a negedge; leaves with the DUT back in IDLE at a negedge
  task automatic run_op(input string tag, input bit id, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] exp_aop, input logic [31:0] exp_res,
                        input logic exp_z, input logic exp_neg, input logic exp_err);
    if (!id) begin
      bus.req0_valid = 1'b1; bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b;
    end
    #1 check({tag, ".grant"}, {30'd0, bus.req1_ready, bus.req0_ready}, id ? 32'd2 : 32'd1);
    @(negedge clk);
    idle_inputs();
    #1 check({tag, ".exrdy"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    check({tag, ".aop"}, {28'd0, bus.alu_opcode}, {28'd0, exp_aop});
    check({tag, ".aa"},  bus.alu_a, a);
    @(negedge clk);
    #1 check({tag, ".rspv"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, id ? 32'd2 : 32'd1);
    check({tag, ".res"}, bus.rsp_result, exp_res);
    check({tag, ".flags"}, {29'd0, bus.rsp_err, bus.rsp_z, bus.rsp_neg},
          {29'd0, exp_err, exp_z, exp_neg});
    @(negedge clk);
    #1 check({tag, ".done"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
  endtask

  initial begin
    idle_inputs();
    // Reset held with a live request: nothing may be granted
    bus.req0_valid = 1'b1;
    @(negedge clk);
    #1 check_reset_outputs("rst");
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b1;

    // Single requester add
    run_op("add0", 1'b0, 4'b1000, 32'd5, 32'd7, 4'b1000, 32'd12, 1'b0, 1'b0, 1'b0);

    // Both requesters valid continuously straight out of reset
    reset_n = 1'b0;
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_opcode = 4'b1000; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_opcode = 4'b0100; bus.req1_a = 32'd0; bus.req1_b = 32'd4;
    #1 check("rr.rst", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] er, ev;
      er = '0; ev = '0;
      if (k % 3 == 0) er[(k / 3) % 2] = 1'b1;
      if (k % 3 == 2) ev[(k / 3) % 2] = 1'b1;
      #1 check($sformatf("rr.rdy%0d", k), {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, er});
      check($sformatf("rr.rsp%0d", k), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, {30'd0, ev});
      if (k == 5)  check("rr.res1", bus.rsp_result, 32'd5);
      if (k == 8)  check("rr.res0", bus.rsp_result, 32'd2);
      @(negedge clk);
    end
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Subtract to zero, then pass B leaves req1 flags untouched
    run_op("sub1",  1'b1, 4'b0001, 32'd9, 32'd9, 4'b0001, 32'h0, 1'b1, 1'b0, 1'b0);
    run_op("pass1", 1'b1, 4'b1111, 32'd0, 32'h80000000, 4'b1111, 32'h80000000, 1'b1, 1'b0, 1'b0);
    // Negate on req0, increment on req1, then NOP on req0 shows req0 flags
    run_op("neg0",  1'b0, 4'b0010, 32'd0, 32'd1, 4'b0010, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    run_op("inc1",  1'b1, 4'b0100, 32'd0, 32'd0, 4'b0100, 32'd1, 1'b0, 1'b0, 1'b0);
    run_op("nop0",  1'b0, 4'b0000, 32'd3, 32'd3, 4'b0000, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    // Unsupported opcode: forced NOP, zero result, error, flags kept
    run_op("bad0",  1'b0, 4'b0110, 32'd3, 32'd4, 4'b0000, 32'h0, 1'b0, 1'b1, 1'b1);
    run_op("ok1",   1'b1, 4'b1000, 32'd2, 32'd3, 4'b1000, 32'd5, 1'b0, 1'b0, 1'b0);

    // Reset during EXEC kills the operation
    bus.req0_valid = 1'b1; bus.req0_opcode = 4'b1000; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
    #1 check("kill.grant", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1 check("kill.aop", {28'd0, bus.alu_opcode}, 32'd8);
    reset_n = 1'b0;
    #1 check_reset_outputs("kill");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check($sformatf("kill.rsp%0d", k), {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    #1 check_reset_outputs("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001: clk  input  1  rising-edge clock for all state.
REQ-002: reset_n  input  1  asynchronous, active-low reset.
REQ-003: reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-004: reqN_ready  output  1  (N=0,1) operation of requester N accepted this cycle.
REQ-005: reqN_opcode  input  4  (N=0,1) ALU opcode: 1000 A+B, 0100 B+1, 0010 -B, 0001 B-A, 1111 pass B, 0000 NOP.
REQ-006: reqN_a, reqN_b  input  32 each  (N=0,1) operands.
REQ-007: alu_opcode  output  4  opcode driven to the shared ALU.
REQ-008: alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-009: alu_result  input  32  combinational ALU result.
REQ-010: alu_z, alu_neg  input  1 each  ALU zero and negative flags.
REQ-011: rspN_valid  output  1  (N=0,1) one-cycle response strobe to requester N.
REQ-012: rsp_result  output  32  result of the completed operation.
REQ-013: rsp_z, rsp_neg  output  1 each  flags of the responding requester after the operation.
REQ-014: rsp_err  output  1  completed operation had an unsupported opcode.

Function
REQ-015: FSM states IDLE, EXEC, RESP; IDLE->EXEC on grant, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-016: In IDLE with any reqN_valid high, grant exactly one requester; reqN_ready high for that requester only, in that same cycle (combinational on valid and state).
REQ-017: Arbitration round-robin: single valid requester wins; both valid -> requester not granted last wins; last_grant resets to 1 so req0 wins the first tie.
REQ-018: On the grant edge, latch granted opcode, A, B and requester id into internal registers; requester inputs are don't-care afterwards.
REQ-019: reqN_ready low in EXEC and RESP; no request accepted outside IDLE.
REQ-020: In EXEC, alu_opcode/alu_a/alu_b driven from latched registers; otherwise driven 4'b0000 / 32'h0 / 32'h0.
REQ-021: At the end of EXEC, capture alu_result into rsp_result; rsp_result holds until the next capture.
REQ-022: Per-requester flag registers (z0,neg0,z1,neg1); opcodes 1000, 0100, 0010, 0001 load the granted requester's flags from alu_z/alu_neg at end of EXEC.
REQ-023: Opcodes 1111 and 0000 leave the granted requester's flags unchanged; the other requester's flags never change.
REQ-024: Unsupported opcode (any other encoding): drive alu_opcode 0000 in EXEC, capture rsp_result = 32'h0, flags unchanged, rsp_err = 1; otherwise rsp_err = 0.
REQ-025: In RESP, rspN_valid high for exactly one cycle for the granted requester; rsp_z/rsp_neg show that requester's flag registers.
REQ-026: Latency: ready at cycle T -> rspN_valid at cycle T+2; throughput one operation per 3 cycles.
REQ-027: No response backpressure; requesters must sample in the rspN_valid cycle.
REQ-028: Arithmetic is modulo 2^32 as computed by the ALU; the arbiter performs no arithmetic.

Reset
REQ-029: reset_n low asynchronously forces IDLE, last_grant=1, all flag registers 0, rsp_result 0, rsp_err 0, rspN_valid 0, reqN_ready 0, ALU drive 0000/0/0.
REQ-030: Reset during EXEC or RESP discards the in-flight operation; no rspN_valid is produced for it.
REQ-031: After reset_n rises, the first grant occurs no earlier than the first rising edge with reset_n high.

Verification
REQ-032: req0 A=5,B=7,op 1000 alone -> req0_ready at T, rsp0_valid at T+2, result 12, z=0, neg=0.
REQ-033: Both valid back-to-back from reset -> grants req0, req1, req0, req1 in turn, each grant 3 cycles apart.
REQ-034: req1 op 0001 A=9,B=9 -> result 0, z1=1; then req1 op 1111 B=32'h80000000 -> result 32'h80000000, rsp_z=1, rsp_neg=0.
REQ-035: req0 op 0010 B=1 -> result 32'hFFFFFFFF, neg0=1; then req1 op 0100 B=0 -> result 1, rsp_z=0, rsp_neg=0, req0 flags still neg=1.
REQ-036: req0 op 0110 -> rsp_err=1, result 0, flags unchanged; reset_n pulsed low during EXEC of a following op -> no rsp0_valid, all outputs at reset values.
